// File: rtl/data_mem_if.sv
// data_mem_if -- SRAM-style bus between the core and data_mem.
//   CEN  : chip enable, active-low
//   WEN  : write enable, active-low
//   OEN  : output enable, active-low
//   A    : word address (ADDR_W bits)
//   D    : write data (DATA_W bits)
//   Q    : read data (DATA_W bits)
// Modports: master (core side) drives CEN/WEN/OEN/A/D, slave (memory) drives Q.
interface data_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
);
   logic              CEN;
   logic              WEN;
   logic              OEN;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] D;
   logic [DATA_W-1:0] Q;

   modport master (output CEN, output WEN, output OEN, output A, output D, input Q);
   modport slave  (input CEN, input WEN, input OEN, input A, input D, output Q);
endinterface

// File: rtl/data_mem.sv
// data_mem -- 2^ADDR_W x DATA_W data memory for a single-cycle core.
// Reads return mem[A] combinationally on Q; in all other cycles Q shows the
// last read value (q_hold). Writes commit on the rising edge.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset; clears memory, q_hold, flags, counters
//   bus       : data_mem_if slave (CEN, WEN, OEN, A, D, Q)
//   conflict  : sticky, set by any cycle with CEN=0, WEN=0, OEN=0
//   rd_count  : saturating read-access count (0 unless stats enabled)
//   wr_count  : saturating write-access count (0 unless stats enabled)
//   dbg_addr  : backdoor read address
//   dbg_data  : mem[dbg_addr], combinational
// Build option: define DATA_MEM_STATS_EN to implement rd_count/wr_count.
module data_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   data_mem_if.slave         bus,
   output logic              conflict,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] q_hold;
   logic              rd_cyc;
   logic              wr_cyc;
   logic              cf_cyc;

   // A write takes priority over OEN, so a conflict cycle is a write and never a read.
   always_comb begin
      wr_cyc = !bus.CEN && !bus.WEN;
      rd_cyc = !bus.CEN &&  bus.WEN && !bus.OEN;
      cf_cyc = wr_cyc && !bus.OEN;
   end

   always_comb begin
      bus.Q    = rd_cyc ? mem[bus.A] : q_hold;
      dbg_data = mem[dbg_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem      <= '{default: '0};
         q_hold   <= '0;
         conflict <= 1'b0;
      end else begin
         if (wr_cyc) mem[bus.A] <= bus.D;
         if (rd_cyc) q_hold <= mem[bus.A];
         if (cf_cyc) conflict <= 1'b1;
      end
   end

`ifdef DATA_MEM_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_cyc && (rd_count != '1)) rd_count <= rd_count + 16'd1;
         if (wr_cyc && (wr_count != '1)) wr_count <= wr_count + 16'd1;
      end
   end
`else
   always_comb begin
      rd_count = '0;
      wr_count = '0;
   end
`endif

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        conflict;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic [6:0]  dbg_addr;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;

`ifdef DATA_MEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   data_mem_if #(.DATA_W(32), .ADDR_W(7)) bus ();

   data_mem #(.DATA_W(32), .ADDR_W(7)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .conflict (conflict),
      .rd_count (rd_count),
      .wr_count (wr_count),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   // Apply one cycle's inputs just after an edge; checks happen mid-cycle.
   task automatic drive(input logic r, input logic c, input logic w, input logic o,
                        input logic [6:0] a, input logic [31:0] d);
      rst_n   = r;
      bus.CEN = c;
      bus.WEN = w;
      bus.OEN = o;
      bus.A   = a;
      bus.D   = d;
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      dbg_addr = '0;
      @(posedge clk); #1;
      // reset cycle
      drive(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0); tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      chk("rst_q", bus.Q, 32'h0);
      chk("rst_conflict", {31'b0, conflict}, 32'h0);
      chk("rst_rd_count", {16'b0, rd_count}, 32'h0);
      chk("rst_wr_count", {16'b0, wr_count}, 32'h0);
      tick();
      // write 5
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
      chk("wr_q_not_d", bus.Q, 32'h0);
      tick();
      // read 5
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
      chk("rd5_q", bus.Q, 32'hDEADBEEF);
      tick();
      // idle with other address
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd9, 32'h12345678);
      chk("idle_hold_q", bus.Q, 32'hDEADBEEF);
      chk("cnt_wr1", {16'b0, wr_count}, cnt(1));
      chk("cnt_rd1", {16'b0, rd_count}, cnt(1));
      tick();
      // write 9 -> Q keeps q_hold
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd9, 32'h00000055);
      chk("wr9_q_hold", bus.Q, 32'hDEADBEEF);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd9, 32'h0);
      chk("rd9_q", bus.Q, 32'h00000055);
      tick();
      // conflict cycle
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 32'h00001234);
      chk("cf_q_hold", bus.Q, 32'h00000055);
      chk("cf_before", {31'b0, conflict}, 32'h0);
      tick();
      dbg_addr = 7'd3;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      chk("cf_after", {31'b0, conflict}, 32'h1);
      chk("cf_mem3", dbg_data, 32'h00001234);
      chk("cf_rd_count", {16'b0, rd_count}, cnt(2));
      chk("cf_wr_count", {16'b0, wr_count}, cnt(3));
      tick();
      // double-precision pair at top of memory
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd127, 32'hAAAA5555); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd126, 32'h3FF00000); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd127, 32'h00000000); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 32'h0);
      chk("rd127_q", bus.Q, 32'h0);
      dbg_addr = 7'd126; #1;
      chk("dbg126", dbg_data, 32'h3FF00000);
      dbg_addr = 7'd127; #1;
      chk("dbg127", dbg_data, 32'h00000000);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd126, 32'h0);
      chk("rd126_q", bus.Q, 32'h3FF00000);
      chk("pair_wr_count", {16'b0, wr_count}, cnt(6));
      chk("conflict_sticky", {31'b0, conflict}, 32'h1);
      tick();
      // reset with simultaneous write
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd10, 32'hFFFFFFFF); tick();
      dbg_addr = 7'd10;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      chk("rst_mem10", dbg_data, 32'h0);
      chk("rst2_q", bus.Q, 32'h0);
      chk("rst2_conflict", {31'b0, conflict}, 32'h0);
      chk("rst2_rd_count", {16'b0, rd_count}, 32'h0);
      chk("rst2_wr_count", {16'b0, wr_count}, 32'h0);
      dbg_addr = 7'd5; #1;
      chk("rst_mem5", dbg_data, 32'h0);
      tick();
      // first access after reset
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd126, 32'h0);
      chk("post_rst_rd", bus.Q, 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      chk("post_rst_rd_count", {16'b0, rd_count}, cnt(1));
      tick();
      // saturation
      drive(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 32'h0);
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
      chk("sat_rd_count", {16'b0, rd_count}, STATS ? 32'h0000FFFF : 32'h0);
      chk("sat_wr_count", {16'b0, wr_count}, 32'h0);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, meaning the word-address width; depth is 2^ADDR_W = 128 words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port CEN, input, 1 bit: chip enable, active-low.
REQ-006 SHALL have port WEN, input, 1 bit: write enable, active-low.
REQ-007 SHALL have port OEN, input, 1 bit: output enable, active-low.
REQ-008 SHALL have port A, input, ADDR_W bits: word address.
REQ-009 SHALL have port D, input, DATA_W bits: write data.
REQ-010 SHALL have port Q, output, DATA_W bits: read data.
REQ-011 SHALL have port conflict, output, 1 bit: sticky flag for an illegal access.
REQ-012 SHALL have port rd_count, output, 16 bits: count of read accesses.
REQ-013 SHALL have port wr_count, output, 16 bits: count of write accesses.
REQ-014 SHALL have port dbg_addr, input, ADDR_W bits: backdoor read address.
REQ-015 SHALL have port dbg_data, output, DATA_W bits: backdoor read data, equal to mem[dbg_addr] combinationally.

Function
REQ-016 SHALL treat a cycle as a read when CEN=0, WEN=1 and OEN=0.
REQ-017 SHALL treat a cycle as a write when CEN=0 and WEN=0.
REQ-018 SHALL treat a cycle as idle when CEN=1; WEN, OEN, A and D are then ignored.
REQ-019 SHALL drive Q combinationally with mem[A] during a read cycle (zero-cycle latency, as the single-cycle core requires).
REQ-020 SHALL latch the value of mem[A] into q_hold on the rising edge ending a read cycle.
REQ-021 SHALL drive Q from q_hold in every non-read cycle.
REQ-022 SHALL commit D into mem[A] on the rising edge ending a write cycle; the new value is visible to reads from the next cycle.
REQ-023 SHALL, in a write cycle, drive Q from q_hold, never from the data being written.
REQ-024 SHALL set conflict at the edge ending any cycle with CEN=0, WEN=0 and OEN=0.
REQ-025 SHALL still perform the write in such a conflict cycle and SHALL NOT count it as a read.
REQ-026 SHALL keep conflict set until reset.
REQ-027 SHALL treat back-to-back accesses to A and A+1 (double-precision pairs) as two independent accesses, with no hazard between them.
REQ-028 SHALL wrap address arithmetic modulo 128; A=127 is a valid address and no access is out of range.
REQ-029 SHALL increment rd_count by one per read cycle and wr_count by one per write cycle.
REQ-030 SHALL saturate rd_count and wr_count at 16'hFFFF; neither counter wraps.

Reset
REQ-031 SHALL, on a rising edge with rst_n=0, clear all 128 words to 0, q_hold to 0, conflict to 0, and both counters to 0, in that single cycle.
REQ-032 SHALL make reset override a simultaneous write: the addressed word reads 0 afterwards.
REQ-033 SHALL give Q=0, conflict=0, rd_count=0 and wr_count=0 in the first cycle after reset.
REQ-034 SHALL, when reset is asserted mid-sequence, discard any in-flight state so that the next access behaves as the first access after reset.

Configuration
REQ-035 SHALL, with macro DATA_MEM_STATS_EN defined, implement rd_count and wr_count as specified in REQ-029 and REQ-030.
REQ-036 SHALL, without DATA_MEM_STATS_EN, tie rd_count and wr_count to 0 and implement no counter registers.
REQ-037 SHALL keep the port list identical whether or not DATA_MEM_STATS_EN is defined.

Verification
REQ-038 SHALL cover reset then write: write D=32'hDEADBEEF to A=5, then read A=5 -> Q=32'hDEADBEEF in the read cycle; wr_count=1, rd_count=1 (STATS_EN).
REQ-039 SHALL cover read then idle: read A=5 returning 32'hDEADBEEF, then CEN=1 with A=9 -> Q holds 32'hDEADBEEF.
REQ-040 SHALL cover a conflict cycle: CEN=0, WEN=0, OEN=0, A=3, D=32'h1234 -> conflict=1 from the next cycle, mem[3]=32'h1234, rd_count unchanged.
REQ-041 SHALL cover a double-precision pair: write 32'h3FF00000 to A=126, then 32'h0 to A=127; backdoor reads dbg_addr=126 and dbg_addr=127 -> both values correct.
REQ-042 SHALL cover reset mid-traffic: rst_n=0 together with a write of 32'hFFFFFFFF to A=10 -> mem[10]=0, Q=0, counters=0.
REQ-043 SHALL cover counter saturation: 65,540 consecutive reads -> rd_count=16'hFFFF with STATS_EN; rd_count=0 without it.
